// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-write controller.
// Frame layout is {rw, addr[6:0], data[7:0]}, sent MSB first.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // Register map of the peripheral's register file
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period timer: counts 0..CLK_DIV-1 and flags the last cycle of
// each half-period. i_clear holds the count at 0 so the next phase
// starts with a full CLK_DIV-cycle period.
module spi_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_hc;

    // Free-running half-period count, wrapping at CLK_DIV-1
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_hc <= '0;
        end else if (r_hc == LAST) begin
            r_hc <= '0;
        end else begin
            r_hc <= r_hc + CW'(1);
        end
    end

    assign o_tick = (r_hc == LAST) && !i_clear;

endmodule

// File: rtl/spi_reg_controller.sv
// SPI mode-0 initiator writing the peripheral register file.
// One request per valid/ready handshake becomes one 16-bit frame.
// Optional receive path: define SPI_REG_CONTROLLER_CIPO_EN to add CIPO
// and rdata (last 8 bit periods captured, published with done).
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// SETUP | nCS low, SCLK low, first bit on COPI
// SHIFT | 16 bit periods, SCLK high then low
// HOLD  | nCS low after last bit, SCLK low
// GAP   | nCS high recovery before next frame
module spi_reg_controller
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              busy,
    output logic              done,
    output logic              SCLK,
    output logic              COPI,
    output logic              nCS
`ifdef SPI_REG_CONTROLLER_CIPO_EN
    ,
    input  logic              CIPO,
    output logic [DATA_W-1:0] rdata
`endif
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_t                r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [3:0]            r_bit;
    logic                  r_sclk;
    logic                  r_ncs;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_tick;
    logic                  w_clear;

    // Timer is held clear while idle and through the done cycle, which
    // stretches GAP by one cycle beyond the done pulse.
    assign w_clear = (r_state == IDLE) || r_done;

    spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    // Frame sequencer with registered SPI and handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
            r_ncs   <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && r_ready) begin
                        r_shift <= pack_frame(req_rw, req_addr, req_data);
                        r_bit   <= '0;
                        r_ncs   <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_sclk  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (r_sclk) begin
                            // Falling edge: next bit appears; zero fills behind the last bit
                            r_sclk  <= 1'b0;
                            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                        end else if (r_bit == LAST_BIT) begin
                            r_state <= HOLD;
                        end else begin
                            r_bit  <= r_bit + 4'd1;
                            r_sclk <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_ncs   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (w_tick) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign SCLK      = r_sclk;
    assign nCS       = r_ncs;
    assign COPI      = r_shift[FRAME_BITS-1];

`ifdef SPI_REG_CONTROLLER_CIPO_EN
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rdata;
    logic              w_rx_rise;

    // Rising edge of bit periods 8..15 (frame bits 7..0)
    assign w_rx_rise = (r_state == SHIFT) && w_tick && !r_sclk &&
                       (r_bit >= 4'd7) && (r_bit != LAST_BIT);

    // Receive shift register, published to rdata with done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx    <= '0;
            r_rdata <= '0;
        end else begin
            if (w_rx_rise) begin
                r_rx <= {r_rx[DATA_W-2:0], CIPO};
            end
            if ((r_state == HOLD) && w_tick) begin
                r_rdata <= r_rx;
            end
        end
    end

    assign rdata = r_rdata;
`endif

endmodule

// File: tb/tb_spi_reg_controller.sv
// Bench for spi_reg_controller with a behavioural model of the SPI
// peripheral register file (captures COPI on SCLK rise, commits a write
// when nCS rises after exactly 16 bits).
module tb_spi_reg_controller;
    import spi_reg_pkg::*;

    localparam int CLK_DIV   = 4;
    localparam int NCS_LOW   = 34 * CLK_DIV;
    localparam int ACC2DONE  = 34 * CLK_DIV + 1;
    localparam int SPACING   = 35 * CLK_DIV + 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rw    = 1'b0;
    logic [6:0] req_addr  = '0;
    logic [7:0] req_data  = '0;
    logic       req_ready, busy, done, SCLK, COPI, nCS;
`ifdef SPI_REG_CONTROLLER_CIPO_EN
    logic       CIPO = 1'b0;
    logic [7:0] rdata;
    logic [7:0] rx_pat = 8'hA5;
`endif

    spi_reg_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .busy      (busy),
        .done      (done),
        .SCLK      (SCLK),
        .COPI      (COPI),
        .nCS       (nCS)
`ifdef SPI_REG_CONTROLLER_CIPO_EN
        ,
        .CIPO      (CIPO),
        .rdata     (rdata)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Cycle counter, acceptance log, done/accept overlap detector
    int cyc     = 0;
    int acc_cnt = 0;
    int overlap = 0;
    int acc_q[$];
    always @(posedge clk) begin
        cyc++;
        if (rst_n && req_valid && req_ready) begin
            acc_cnt++;
            acc_q.push_back(cyc);
        end
        if (rst_n && done && req_valid && req_ready) overlap++;
    end

    // Mid-cycle monitor: nCS low cycles, done pulses, shortest nCS-high gap
    int ncs_low_cnt = 0;
    int done_cnt    = 0;
    int high_run    = 0;
    int min_gap     = 1000;
    bit gap_track   = 0;
    always @(negedge clk) begin
        if (nCS === 1'b0) begin
            if (gap_track && high_run > 0 && high_run < min_gap) min_gap = high_run;
            high_run = 0;
            ncs_low_cnt++;
        end else begin
            high_run++;
        end
        if (!gap_track) min_gap = 1000;
        if (done === 1'b1) done_cnt++;
    end

    // Peripheral model
    logic [15:0] cap        = '0;
    int          cap_bits   = 0;
    logic [15:0] last_frame = '0;
    int          last_bits  = 0;
    int          frames_seen = 0;
    logic        ncs_q      = 1'b1;
    logic [7:0]  preg [0:4] = '{default: 8'h00};
    always @(posedge SCLK or nCS) begin
        if (nCS !== ncs_q) begin
            if (nCS === 1'b0) begin
                cap      = '0;
                cap_bits = 0;
            end else begin
                last_frame = cap;
                last_bits  = cap_bits;
                frames_seen++;
                if (cap_bits == 16 && cap[15] && int'(cap[14:8]) <= 4)
                    preg[int'(cap[14:8])] = cap[7:0];
            end
            ncs_q = nCS;
        end else if (SCLK === 1'b1 && nCS === 1'b0) begin
            cap = {cap[14:0], COPI};
            cap_bits++;
        end
    end

`ifdef SPI_REG_CONTROLLER_CIPO_EN
    // Peripheral drives read-back bits 7..0 ahead of rises 8..15
    always @(negedge SCLK) begin
        if (cap_bits >= 8 && cap_bits <= 15) CIPO = rx_pat[15 - cap_bits];
    end
`endif

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        logic [15:0] frame;
        int         reg_idx;
        logic [7:0] reg_val;
    } vec_t;

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (req_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = (req_ready === 1'b1);
    endtask

    // Returns the cycle count at the edge where done is sampled high
    task automatic wait_done(output bit ok, output int dcyc, input bit scramble);
        int n = 0;
        ok = 0;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
            if (scramble) begin
                req_addr = 7'($urandom);
                req_data = 8'($urandom);
                req_rw   = 1'($urandom);
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        dcyc = cyc;
    endtask

    task automatic send_check(input vec_t v, input bit scramble, input string tag);
        bit ok;
        int acc, dcyc, ncs0, dn0;
        @(negedge clk);
        req_rw    = v.rw;
        req_addr  = v.addr;
        req_data  = v.data;
        req_valid = 1'b1;
        wait_ready(ok);
        if (!ok) check({tag, "_ready_timeout"}, 0, 1);
        ncs0 = ncs_low_cnt;
        dn0  = done_cnt;
        @(posedge clk);
        #1;
        acc       = cyc;
        req_valid = 1'b0;
        wait_done(ok, dcyc, scramble);
        check({tag, "_done_seen"}, 32'(ok), 1);
        check({tag, "_acc_to_done"}, 32'(dcyc - acc), ACC2DONE);
        @(negedge clk);
        wait_ready(ok);
        check({tag, "_frame"}, 32'(last_frame), 32'(v.frame));
        check({tag, "_bits"}, 32'(last_bits), 16);
        check({tag, "_ncs_low"}, 32'(ncs_low_cnt - ncs0), NCS_LOW);
        check({tag, "_done_pulses"}, 32'(done_cnt - dn0), 1);
        check({tag, "_preg"}, 32'(preg[v.reg_idx]), 32'(v.reg_val));
    endtask

    vec_t vecs[4];

    initial begin
        bit ok;
        int d, a0, f0, dn0;
        vec_t v;

        vecs[0] = '{1'b1, ADDR_PWM_DUTY,    8'h80, 16'h8480, 4, 8'h80};
        vecs[1] = '{1'b0, ADDR_EN_PWM_7_0,  8'h55, 16'h0255, 2, 8'h00};
        vecs[2] = '{1'b1, ADDR_EN_PWM_15_8, 8'h5A, 16'h835A, 3, 8'h5A};
        vecs[3] = '{1'b1, ADDR_EN_OUT_15_8, 8'hC3, 16'h81C3, 1, 8'hC3};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ncs", 32'(nCS), 1);
        check("rst_sclk", 32'(SCLK), 0);
        check("rst_copi", 32'(COPI), 0);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;

        // Table-driven single frames
        for (int i = 0; i < 4; i++) send_check(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Back-to-back writes with req_valid held high
        @(negedge clk);
        gap_track = 1;
        a0 = acc_cnt;
        f0 = frames_seen;
        req_valid = 1'b1;
        req_rw    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 7'(i);
            req_data = 8'hFF;
            wait_ready(ok);
            if (!ok) check("b2b_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        wait_done(ok, d, 1'b0);
        check("b2b_last_done", 32'(ok), 1);
        @(negedge clk);
        wait_ready(ok);
        @(negedge clk);
        gap_track = 0;
        check("b2b_accepts", 32'(acc_cnt - a0), 4);
        check("b2b_frames", 32'(frames_seen - f0), 4);
        check("b2b_min_gap_ge4", 32'(min_gap >= 4), 1);
        for (int i = 1; i < 4; i++)
            check($sformatf("b2b_spacing%0d", i),
                  32'(acc_q[acc_q.size() - 4 + i] - acc_q[acc_q.size() - 5 + i]), SPACING);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b_preg%0d", i), 32'(preg[i]), 8'hFF);

        // Request inputs scrambled while the frame is in flight
        v = '{1'b1, ADDR_PWM_DUTY, 8'h3C, 16'h843C, 4, 8'h3C};
        send_check(v, 1'b1, "scramble");

        // Reset after the 5th SCLK rise aborts the frame
        @(negedge clk);
        req_rw = 1'b1; req_addr = ADDR_EN_OUT_7_0; req_data = 8'h11; req_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        d = 0;
        do begin
            @(negedge clk);
            d++;
        end while (cap_bits < 5 && d < 1000);
        check("abort_reach5", 32'(cap_bits), 5);
        dn0 = done_cnt;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ncs", 32'(nCS), 1);
        check("abort_sclk", 32'(SCLK), 0);
        check("abort_copi", 32'(COPI), 0);
        check("abort_done", 32'(done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dn0), 0);
        check("abort_bits", 32'(last_bits), 5);
        check("abort_preg0", 32'(preg[0]), 8'hFF);
        v = '{1'b1, ADDR_EN_OUT_7_0, 8'h3C, 16'h803C, 0, 8'h3C};
        send_check(v, 1'b0, "post_abort");

`ifdef SPI_REG_CONTROLLER_CIPO_EN
        // Read-back capture
        @(negedge clk);
        req_rw = 1'b0; req_addr = ADDR_PWM_DUTY; req_data = 8'h00; req_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        d = 0;
        while (done !== 1'b1 && d < 3000) begin
            @(negedge clk);
            d++;
        end
        check("cipo_rdata_done", 32'(rdata), 8'hA5);
        repeat (10) @(negedge clk);
        check("cipo_rdata_hold", 32'(rdata), 8'hA5);
`endif

        check("done_accept_overlap", 32'(overlap), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_reg_controller.md
Name: spi_reg_controller

Overview:
- SPI controller (initiator) that writes the SPI peripheral's register file: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle.
- Accepts one register-write request per valid/ready handshake and serialises it as a 16-bit mode-0 frame on SCLK/COPI/nCS.
- Sits in test/bring-up logic, or on a host-side chip driving ui_in[2:0] of the PWM design.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period. Legal range 4..255; below 4 violates the peripheral's 2-FF synchroniser.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_rw  in  1  frame bit 15; 1=write, 0=read (the peripheral ignores read frames)
- req_addr  in  7  register address
- req_data  in  8  write data
- busy  out  1  frame in progress (state != IDLE)
- done  out  1  one-cycle pulse at frame end
- SCLK  out  1  serial clock, idle low
- COPI  out  1  serial data, MSB first
- nCS  out  1  chip select, active-low

Behaviour:
- Reset values: nCS=1, SCLK=0, COPI=0, req_ready=1, busy=0, done=0; state=IDLE; counters=0.
- Frame format: {req_rw, req_addr[6:0], req_data[7:0]}, MSB first.
- Mode 0: SCLK idles low. COPI changes only while SCLK is low. The peripheral samples on the rising edge.
- Half-period counter hc counts 0..CLK_DIV-1. Each state/phase lasts exactly CLK_DIV cycles.
- IDLE:
  - req_ready=1.
  - On clk edge with req_valid&req_ready: latch the frame into a 16-bit shift register and go to SETUP.
  - From the next cycle: nCS=0, COPI=frame[15], req_ready=0.
- SETUP: CLK_DIV cycles with SCLK=0 (CS-to-first-edge setup), then go to SHIFT.
- SHIFT:
  - 16 bit periods, each SCLK high for CLK_DIV cycles then low for CLK_DIV cycles.
  - At each high-to-low transition, shift left and present the next bit on COPI.
  - Bit counter 0..15. After the 16th low half-period, go to HOLD. COPI is 0 after the last bit.
- HOLD: CLK_DIV cycles; nCS and SCLK stay low. Then nCS=1, done=1 for exactly that one cycle, go to GAP.
- GAP: nCS=1 for CLK_DIV cycles, then IDLE; req_ready=1 from the following cycle.
- Latency:
  - nCS is low for exactly 34*CLK_DIV cycles.
  - Acceptance edge to done = 34*CLK_DIV+1 cycles.
  - Minimum acceptance-to-acceptance spacing = 35*CLK_DIV+2 cycles.
- Request inputs are sampled only at acceptance. Later changes to req_* do not affect the frame in flight.
- req_valid while req_ready=0 is ignored. The requester holds it; nothing is queued.
- Reset asserted mid-frame aborts the frame:
  - After that edge, nCS=1, SCLK=0, COPI=0, no done pulse.
  - The peripheral discards the partial frame because nCS rises before 16 bits.
- Reset has priority over an acceptance on the same edge.
- done and a new acceptance can never occur in the same cycle.

Optional Feature:
- Macro: SPI_REG_CONTROLLER_CIPO_EN.
- Defined:
  - Adds input CIPO (1) and output rdata (8).
  - CIPO is sampled on each SCLK rising edge of bits 7..0 (the last 8 bit periods) into a receive shift register.
  - rdata updates in the done cycle and holds until the next done. Reset value 0x00.
  - An aborted frame leaves rdata unchanged.
- Undefined: no CIPO/rdata ports, no receive logic; behaviour otherwise identical.

Decomposition:
- Package spi_reg_pkg:
  - FRAME_BITS=16, ADDR_W=7, DATA_W=8.
  - State enum {IDLE, SETUP, SHIFT, HOLD, GAP}.
  - Register address constants: ADDR_EN_OUT_7_0=0x00, ADDR_EN_OUT_15_8=0x01, ADDR_EN_PWM_7_0=0x02, ADDR_EN_PWM_15_8=0x03, ADDR_PWM_DUTY=0x04.
- One sub-module, spi_half_period_timer: CLK_DIV counter producing a one-cycle tick at end of each half-period, with synchronous clear on state entry.

Test Plan:
- CLK_DIV=4, write addr 0x04 data 0x80:
  - COPI sampled at the 16 SCLK rising edges = 0x8480.
  - nCS low exactly 136 cycles; one done pulse.
  - Connected peripheral's pwm_duty_cycle becomes 0x80.
- Four back-to-back writes 0x00..0x03 with data 0xFF, req_valid held high:
  - Each accepted only when req_ready=1; nCS high ≥4 cycles between frames.
  - All four enable registers read 0xFF.
- Reset asserted after the 5th SCLK rising edge of a write to 0x00:
  - Next cycle nCS=1, SCLK=0, COPI=0, no done.
  - Peripheral en_reg_out_7_0 unchanged; the following frame completes normally.
- Change req_addr/req_data every cycle during a frame: transmitted frame equals the values present at acceptance.
- req_rw=0, addr 0x02, data 0x55: frame 0x0255 is transmitted; peripheral registers unchanged.
- With SPI_REG_CONTROLLER_CIPO_EN, CIPO driven 0xA5 MSB-first on bits 7..0: rdata=0xA5 in the done cycle, held afterwards.
